// File: rtl/sram_1r1w_masked_array.sv
// ============================================================================
// Module  : sram_1r1w_masked_array
// Brief   : Single-clock 1R1W masked SRAM model with post-reset clearing,
//           write-first bypass and read-data hold. SRAM_OUT_PIPE_EN adds a
//           second output register stage (read latency 2).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sram_1r1w_masked_array #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 219,
    parameter int MASK_GRAN = 219,
    parameter int MASK_SEG  = WIDTH / MASK_GRAN,
    parameter int ADDR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_busy,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_valid,
    output logic [WIDTH-1:0]  r_data,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [MASK_SEG-1:0] w_mask,
    input  logic [WIDTH-1:0]  w_data
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if ((WIDTH % MASK_GRAN) != 0) begin : g_bad_mask_gran
        $error("WIDTH must be a multiple of MASK_GRAN");
    end

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   init_ptr, next_ptr;
    logic [WIDTH-1:0]    mem [DEPTH];

    logic                clear_fire;
    logic                wr_fire;
    logic                rd_fire;
    logic                r_in_range;
    logic                w_in_range;
    logic [WIDTH-1:0]    rd_word;
    logic                s1_valid;
    logic [WIDTH-1:0]    s1_data;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state    <= next_state;
            init_ptr <= next_ptr;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = init_ptr;
        init_busy  = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                if (init_ptr == LAST_ADDR) begin
                    next_state = READY;
                end else begin
                    next_ptr = init_ptr + ADDR_W'(1);
                end
            end
            default: begin
                next_state = READY;
            end
        endcase
    end

    assign r_in_range = ({1'b0, r_addr} < DEPTH_EXT);
    assign w_in_range = ({1'b0, w_addr} < DEPTH_EXT);
    assign clear_fire = reset_n && (state == INIT);
    assign wr_fire    = reset_n && (state == READY) && w_en && w_in_range;
    assign rd_fire    = (state == READY) && r_en;

    always_ff @(posedge clock) begin
        if (clear_fire) begin
            mem[init_ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < MASK_SEG; i++) begin
                if (w_mask[i]) begin
                    mem[w_addr][i*MASK_GRAN +: MASK_GRAN] <= w_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Write-first: masked segments of a same-address write override the old word.
    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            rd_word = mem[r_addr];
        end
        if (wr_fire && (w_addr == r_addr)) begin
            for (int i = 0; i < MASK_SEG; i++) begin
                if (w_mask[i]) begin
                    rd_word[i*MASK_GRAN +: MASK_GRAN] = w_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

`ifdef SRAM_OUT_PIPE_EN
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_data;
            end
        end
    end

    assign r_valid = s2_valid;
    assign r_data  = s2_data;
`else
    assign r_valid = s1_valid;
    assign r_data  = s1_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_1r1w_masked_array.sv
// ============================================================================
// Module  : tb_sram_1r1w_masked_array
// Brief   : Directed, table-driven bench for sram_1r1w_masked_array.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sram_1r1w_masked_array;

`ifdef SRAM_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DEPTH=6 (non power of two), 64-bit, 16-bit mask granule
    logic        rst_a;
    logic        busy_a;
    logic        ra_en;
    logic [2:0]  ra_addr;
    logic        va;
    logic [63:0] da;
    logic        wa_en;
    logic [2:0]  wa_addr;
    logic [3:0]  wa_mask;
    logic [63:0] wa_data;

    // DUT B: default geometry (DEPTH=8, WIDTH=219, single mask bit)
    logic         rst_b;
    logic         busy_b;
    logic         rb_en;
    logic [2:0]   rb_addr;
    logic         vb;
    logic [218:0] db;
    logic         wb_en;
    logic [2:0]   wb_addr;
    logic [0:0]   wb_mask;
    logic [218:0] wb_data;

    sram_1r1w_masked_array #(.DEPTH(6), .WIDTH(64), .MASK_GRAN(16)) u_dut_a (
        .clock     (clk),
        .reset_n   (rst_a),
        .init_busy (busy_a),
        .r_en      (ra_en),
        .r_addr    (ra_addr),
        .r_valid   (va),
        .r_data    (da),
        .w_en      (wa_en),
        .w_addr    (wa_addr),
        .w_mask    (wa_mask),
        .w_data    (wa_data)
    );

    sram_1r1w_masked_array u_dut_b (
        .clock     (clk),
        .reset_n   (rst_b),
        .init_busy (busy_b),
        .r_en      (rb_en),
        .r_addr    (rb_addr),
        .r_valid   (vb),
        .r_data    (db),
        .w_en      (wb_en),
        .w_addr    (wb_addr),
        .w_mask    (wb_mask),
        .w_data    (wb_data)
    );

    typedef struct {
        logic        r_en;
        logic [2:0]  r_addr;
        logic        w_en;
        logic [2:0]  w_addr;
        logic [3:0]  w_mask;
        logic [63:0] w_data;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [218:0] act, input logic [218:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic re, input logic [2:0] ra, input logic we,
                                input logic [2:0] wa, input logic [3:0] wm,
                                input logic [63:0] wd, input logic ev, input logic [63:0] ed);
        vec_t v;
        v.r_en = re; v.r_addr = ra; v.w_en = we; v.w_addr = wa;
        v.w_mask = wm; v.w_data = wd; v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    task automatic read_b(input logic [2:0] a, input logic [218:0] exp, input string tag);
        @(negedge clk);
        rb_en   = 1'b1;
        rb_addr = a;
        @(posedge clk);
        #1;
        rb_en = 1'b0;
        if (LAT == 2) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_valid[%0d]", tag, a), 219'(vb), 219'(1));
        check($sformatf("%s_data[%0d]", tag, a), db, exp);
    endtask

    // Counts edges until init_busy of DUT B falls; flags any r_valid seen meanwhile.
    task automatic count_init_b(output int n, output int valid_seen);
        n = 0;
        valid_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (vb) valid_seen = 1;
            if (!busy_b) begin
                n = c;
                break;
            end
        end
        wb_en = 1'b0;
        rb_en = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        int na, nb, vseen;
        logic [218:0] ones;
        ones = '1;

        vecs.push_back(mk(0, 0, 1, 3, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0));
        vecs.push_back(mk(0, 0, 1, 3, 4'h5, 64'h0,                   0, 64'h0));
        vecs.push_back(mk(1, 3, 0, 0, 4'h0, 64'h0,                   1, 64'hFFFF_0000_FFFF_0000));
        vecs.push_back(mk(0, 0, 1, 2, 4'hF, 64'h1111_2222_3333_4444, 0, 64'hFFFF_0000_FFFF_0000));
        vecs.push_back(mk(1, 2, 1, 2, 4'h3, 64'hAAAA_BBBB_CCCC_DDDD, 1, 64'h1111_2222_CCCC_DDDD));
        vecs.push_back(mk(1, 2, 0, 0, 4'h0, 64'h0,                   1, 64'h1111_2222_CCCC_DDDD));
        vecs.push_back(mk(0, 0, 1, 2, 4'h0, 64'h0,                   0, 64'h1111_2222_CCCC_DDDD));
        vecs.push_back(mk(1, 2, 0, 0, 4'h0, 64'h0,                   1, 64'h1111_2222_CCCC_DDDD));
        vecs.push_back(mk(0, 0, 1, 5, 4'hF, 64'h5A,                  0, 64'h1111_2222_CCCC_DDDD));
        vecs.push_back(mk(1, 5, 0, 0, 4'h0, 64'h0,                   1, 64'h5A));
        vecs.push_back(mk(0, 0, 1, 5, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h5A));
        vecs.push_back(mk(0, 0, 1, 5, 4'hF, 64'h1234,                0, 64'h5A));
        vecs.push_back(mk(0, 0, 1, 5, 4'hF, 64'h77,                  0, 64'h5A));
        vecs.push_back(mk(1, 5, 0, 0, 4'h0, 64'h0,                   1, 64'h77));
        vecs.push_back(mk(0, 0, 1, 7, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h77));
        vecs.push_back(mk(1, 7, 0, 0, 4'h0, 64'h0,                   1, 64'h0));
        vecs.push_back(mk(1, 3, 1, 4, 4'hF, 64'hDEAD_BEEF,           1, 64'hFFFF_0000_FFFF_0000));
        vecs.push_back(mk(1, 4, 0, 0, 4'h0, 64'h0,                   1, 64'hDEAD_BEEF));
        vecs.push_back(mk(1, 6, 0, 0, 4'h0, 64'h0,                   1, 64'h0));
        vecs.push_back(mk(1, 0, 0, 0, 4'h0, 64'h0,                   1, 64'h0));
        vecs.push_back(mk(1, 1, 0, 0, 4'h0, 64'h0,                   1, 64'h0));

        rst_a = 1'b0; ra_en = 1'b0; ra_addr = '0; wa_en = 1'b0; wa_addr = '0; wa_mask = '0; wa_data = '0;
        rst_b = 1'b0; rb_en = 1'b0; rb_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_mask = '0; wb_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy_a",  219'(busy_a), 219'(1));
        check("reset_valid_a", 219'(va),     219'(0));
        check("reset_data_a",  219'(da),     219'(0));
        check("reset_busy_b",  219'(busy_b), 219'(1));
        check("reset_valid_b", 219'(vb),     219'(0));
        check("reset_data_b",  db,           219'(0));

        // Release both resets together and measure each clearing sweep
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        na = 0;
        nb = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (!busy_a && na == 0) na = c;
            if (!busy_b && nb == 0) nb = c;
        end
        check("init_cycles_a", 219'(na), 219'(6));
        check("init_cycles_b", 219'(nb), 219'(8));

        for (int a = 0; a < 8; a++) begin
            read_b(3'(a), '0, "sweep");
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ra_en   = vecs[i].r_en;
            ra_addr = vecs[i].r_addr;
            wa_en   = vecs[i].w_en;
            wa_addr = vecs[i].w_addr;
            wa_mask = vecs[i].w_mask;
            wa_data = vecs[i].w_data;
            @(posedge clk);
            #1;
            ra_en = 1'b0;
            wa_en = 1'b0;
            if (LAT == 2) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d_valid", i), 219'(va), 219'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i),  219'(da), 219'(vecs[i].exp_data));
        end

        // Fill DUT B with ones so the restarted clear is observable
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            wb_en = 1'b1; wb_addr = 3'(a); wb_mask = 1'b1; wb_data = ones;
        end
        @(negedge clk);
        wb_en = 1'b0;
        read_b(3'd6, ones, "filled");

        // Reset, then abort the clearing sweep after 4 cycles with traffic present
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd5; wb_mask = 1'b1; wb_data = ones;
        rb_en = 1'b1; rb_addr = 3'd5;
        vseen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (vb) vseen = 1;
        end
        check("midinit_no_valid", 219'(vseen), 219'(0));
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("midinit_reset_busy",  219'(busy_b), 219'(1));
        check("midinit_reset_valid", 219'(vb),     219'(0));
        @(negedge clk);
        rst_b = 1'b1;
        count_init_b(nb, vseen);
        check("restart_cycles_b",   219'(nb),    219'(8));
        check("restart_no_valid_b", 219'(vseen), 219'(0));
        check("restart_data_b",     db,          219'(0));
        for (int a = 0; a < 8; a++) begin
            read_b(3'(a), '0, "restart");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
